rng_draw: RTL and testbench

RNG_DRAW -- requirements
Module: rng_draw

---
 rtl/rng_pkg.sv | 21 ++
 rtl/lfsr_core.sv | 52 +++++
 rtl/rng_draw.sv | 134 +++++++++++++
 tb/tb_rng_draw.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rng_pkg -- shared definitions for the random-draw block.
//   draw_state_t : draw FSM encoding (IDLE / DRAW / DONE)
//   TAPS_Wn      : default XNOR feedback masks for common LFSR widths
//   TRY_W        : width of the rejection-sampling try counter
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

  localparam logic [3:0]  TAPS_W4  = 4'b1100;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  // Large enough for any attempt limit up to 255.
  localparam int TRY_W = 8;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core -- Fibonacci LFSR with XNOR feedback, seed load and step control.
//   clk    in  clock
//   reset  in  asynchronous, active-high reset (state -> 0)
//   step   in  advance the register by one shift this cycle
//   load   in  load seed this cycle (wins over step)
//   seed   in  seed value; all-ones is replaced by all-zeros
//   state  out current register contents
module lfsr_core
  import rng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] tapped;
  logic             fb;
  logic [WIDTH-1:0] seed_clean;
  logic [WIDTH-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tapped[gi] = state[gi] & TAPS[gi];
    end
  endgenerate

  // XNOR feedback: all-zeros is a legal state, all-ones is the lockup state.
  assign fb      = ~(^tapped);
  assign shifted = {state[WIDTH-2:0], fb};

  // A lockup seed would freeze the register, so it is mapped onto the
  // all-zeros state, which is the natural start of the sequence.
  assign seed_clean = (seed == {WIDTH{1'b1}}) ? '0 : seed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= seed_clean;
    end else if (step) begin
      state <= shifted;
    end
  end

endmodule

// File: rtl/rng_draw.sv
// rng_draw -- bounded random-number draw using rejection sampling on an LFSR.
//   clk        in  clock
//   reset      in  asynchronous, active-high reset
//   enable     in  free-run step request while idle
//   seed_load  in  load seed into the LFSR this cycle
//   seed       in  seed value (WIDTH)
//   req        in  draw request, sampled only while idle
//   limit      in  exclusive upper bound (OUT_W); 0 selects the full range
//   busy       out high while a draw is in progress or being reported
//   valid      out one-cycle result pulse
//   rand_out   out drawn value, held until the next valid
//   timeout    out one-cycle pulse alongside valid when the try limit ran out
//   state_out  out current LFSR state (WIDTH)
module rng_draw
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_W16,
  parameter int               OUT_W     = 4,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rand_out,
  output logic             timeout,
  output logic [WIDTH-1:0] state_out
);

  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  draw_state_t      fsm;
  draw_state_t      fsm_next;
  logic [TRY_W-1:0] tries;
  logic [TRY_W-1:0] tries_next;
  logic [OUT_W-1:0] lim_q;
  logic [OUT_W-1:0] lim_next;
  logic [OUT_W-1:0] rand_next;
  logic             valid_next;
  logic             timeout_next;
  logic             step;
  logic [OUT_W-1:0] cand;
  logic             accept;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .load  (seed_load),
    .seed  (seed),
    .state (state_out)
  );

  // The candidate is taken from the state before this cycle's shift.
  assign cand   = state_out[OUT_W-1:0];
  assign accept = (lim_q == '0) || (cand < lim_q);
  assign busy   = (fsm != IDLE);

  always_comb begin
    fsm_next     = fsm;
    tries_next   = tries;
    lim_next     = lim_q;
    rand_next    = rand_out;
    valid_next   = 1'b0;
    timeout_next = 1'b0;
    step         = 1'b0;

    unique case (fsm)
      IDLE: begin
        step = enable;
        if (req) begin
          fsm_next   = DRAW;
          lim_next   = limit;
          tries_next = '0;
        end
      end

      DRAW: begin
        step = 1'b1;
        if (accept) begin
          rand_next  = cand;
          valid_next = 1'b1;
          fsm_next   = DONE;
        end else if (tries == LAST_TRY) begin
          // Out of attempts: report a zero result flagged as a timeout.
          rand_next    = '0;
          valid_next   = 1'b1;
          timeout_next = 1'b1;
          fsm_next     = DONE;
        end else begin
          tries_next = tries + 1'b1;
        end
      end

      DONE: begin
        // valid/timeout were registered on entry, so they are high for
        // exactly this one cycle.
        fsm_next = IDLE;
      end

      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm      <= IDLE;
      tries    <= '0;
      lim_q    <= '0;
      rand_out <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      fsm      <= fsm_next;
      tries    <= tries_next;
      lim_q    <= lim_next;
      rand_out <= rand_next;
      valid    <= valid_next;
      timeout  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_rng_draw.sv
// tb_rng_draw -- directed bench for rng_draw with a scoreboard on the
// valid/rand_out/timeout result stream. Two instances: dut (MAX_TRIES=8)
// and dut_b (MAX_TRIES=2, for the timeout path).
module tb_rng_draw;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       enable = 1'b0, seed_load = 1'b0, req = 1'b0;
  logic [3:0] seed = 4'h0, limit = 4'h0;
  logic       busy, valid, timeout;
  logic [3:0] rand_out, state_out;

  logic       enable_b = 1'b0, seed_load_b = 1'b0, req_b = 1'b0;
  logic [3:0] seed_b = 4'h0, limit_b = 4'h0;
  logic       busy_b, valid_b, timeout_b;
  logic [3:0] rand_out_b, state_out_b;

  int checks = 0;
  int errors = 0;

  // Expected results as {timeout, rand_out}.
  logic [4:0] exp_a[$];
  logic [4:0] exp_b[$];

  logic [3:0] fr [16] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                          4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

  always #5 clk = ~clk;

  rng_draw #(.WIDTH(4), .TAPS(4'b1100), .OUT_W(4), .MAX_TRIES(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed(seed), .req(req), .limit(limit), .busy(busy), .valid(valid),
    .rand_out(rand_out), .timeout(timeout), .state_out(state_out)
  );

  rng_draw #(.WIDTH(4), .TAPS(4'b1100), .OUT_W(4), .MAX_TRIES(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .seed_load(seed_load_b),
    .seed(seed_b), .req(req_b), .limit(limit_b), .busy(busy_b), .valid(valid_b),
    .rand_out(rand_out_b), .timeout(timeout_b), .state_out(state_out_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic load_a(input logic [3:0] v);
    seed = v; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic load_b(input logic [3:0] v);
    seed_b = v; seed_load_b = 1'b1;
    tick();
    seed_load_b = 1'b0;
  endtask

  // Scoreboard monitors: compare every valid pulse against the queue head.
  always @(negedge clk) begin
    if (!reset && valid) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL result_a: unexpected valid rand=%0h timeout=%0b", rand_out, timeout);
      end else begin
        logic [4:0] e;
        e = exp_a.pop_front();
        if ({timeout, rand_out} !== e) begin
          errors++;
          $display("FAIL result_a: got rand=%0h timeout=%0b expected rand=%0h timeout=%0b",
                   rand_out, timeout, e[3:0], e[4]);
        end else begin
          $display("ok   result_a: rand=%0h timeout=%0b", rand_out, timeout);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && valid_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL result_b: unexpected valid rand=%0h timeout=%0b", rand_out_b, timeout_b);
      end else begin
        logic [4:0] e;
        e = exp_b.pop_front();
        if ({timeout_b, rand_out_b} !== e) begin
          errors++;
          $display("FAIL result_b: got rand=%0h timeout=%0b expected rand=%0h timeout=%0b",
                   rand_out_b, timeout_b, e[3:0], e[4]);
        end else begin
          $display("ok   result_b: rand=%0h timeout=%0b", rand_out_b, timeout_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset values
    tick(); tick();
    check("rst_state", state_out, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_rand", rand_out, 4'h0);
    check("rst_state_b", state_out_b, 4'h0);

    // Free-run through the full period
    reset = 1'b0;
    enable = 1'b1;
    check("free_run_0", state_out, fr[0]);
    for (int k = 1; k < 16; k++) begin
      tick();
      check($sformatf("free_run_%0d", k), state_out, fr[k]);
    end

    // Lockup seed becomes zero, stepping resumes
    seed = 4'hF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("lockup_load", state_out, 4'h0);
    tick();
    check("lockup_step", state_out, 4'h1);
    enable = 1'b0;

    // Best-case draw: state 0, limit 3 -> 0 accepted
    load_a(4'h0);
    check("draw_seed", state_out, 4'h0);
    limit = 4'd3; req = 1'b1;
    exp_a.push_back({1'b0, 4'h0});
    tick();
    req = 1'b0; limit = 4'hF;
    check("draw_busy_draw", busy, 1'b1);
    check("draw_no_valid_yet", valid, 1'b0);
    check("draw_state_hold_idle", state_out, 4'h0);
    tick();
    check("draw_busy_done", busy, 1'b1);
    check("draw_valid_done", valid, 1'b1);
    check("draw_state_stepped", state_out, 4'h1);
    tick();
    check("draw_busy_end", busy, 1'b0);
    check("draw_valid_end", valid, 1'b0);
    check("draw_no_step_done", state_out, 4'h1);

    // Rejection: state 7, limit 5 -> 7 rejects, 2 accepted on try 8.
    // limit changes after latch and a mid-draw req must both be ignored.
    load_a(4'h7);
    limit = 4'd5; req = 1'b1;
    exp_a.push_back({1'b0, 4'h2});
    tick();
    req = 1'b0; limit = 4'd0;
    n = 0;
    while (busy && n < 40) begin
      req = (n == 3);
      tick();
      n++;
    end
    req = 1'b0;
    check("reject_busy_cycles", n, 9);
    check("reject_state_after", state_out, 4'h5);

    // req held high across DONE starts a second draw (limit 0 = full range)
    limit = 4'd0; req = 1'b1;
    exp_a.push_back({1'b0, 4'h5});
    exp_a.push_back({1'b0, 4'hA});
    tick(); tick(); tick(); tick();
    req = 1'b0;
    tick(); tick();
    check("hold_req_busy", busy, 1'b0);
    check("hold_req_state", state_out, 4'h4);

    // DUT B: a normal draw first so rand_out is nonzero, then a timeout
    load_b(4'h7);
    limit_b = 4'd0; req_b = 1'b1;
    exp_b.push_back({1'b0, 4'h7});
    tick();
    req_b = 1'b0;
    tick(); tick();
    check("b_draw_idle", busy_b, 1'b0);
    check("b_draw_rand_held", rand_out_b, 4'h7);
    load_b(4'h7);
    limit_b = 4'd5; req_b = 1'b1;
    exp_b.push_back({1'b1, 4'h0});
    tick();
    req_b = 1'b0;
    n = 0;
    while (busy_b && n < 40) begin
      tick();
      n++;
    end
    check("timeout_busy_cycles", n, 3);
    check("timeout_cleared", timeout_b, 1'b0);

    // Reset in the middle of a draw aborts it immediately
    load_a(4'h7);
    limit = 4'd5; req = 1'b1;
    exp_a.push_back({1'b0, 4'h2});
    tick();
    req = 1'b0;
    tick();
    check("abort_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_state", state_out, 4'h0);
    check("abort_valid", valid, 1'b0);
    check("abort_rand", rand_out, 4'h0);
    check("abort_timeout", timeout, 1'b0);
    void'(exp_a.pop_back());
    tick(); tick();
    reset = 1'b0;
    limit = 4'd3; req = 1'b1;
    exp_a.push_back({1'b0, 4'h0});
    tick();
    req = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("after_abort_busy_cycles", n, 2);
    check("after_abort_state", state_out, 4'h1);

    tick(); tick();
    check("queue_a_empty", exp_a.size(), 0);
    check("queue_b_empty", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
